// File: rtl/isp_cfg_pkg.sv
// Shared definitions for the ISP front-end configuration controller.
//   - register map indices and per-field widths/offsets into the packed
//     configuration vector
//   - enable bit positions inside the enable register
//   - reset defaults (unity gain) and the commit FSM state encoding
package isp_cfg_pkg;

    localparam int CFG_AW     = 4;
    localparam int CFG_DW     = 16;
    localparam int NUM_FIELDS = 12;
    localparam int EN_W       = 13;
    localparam int NR_W       = 4;
    localparam int GAIN_W     = 8;

    // Register map
    localparam int ADDR_EN           = 0;
    localparam int ADDR_DPC_THR      = 1;
    localparam int ADDR_BLC_R        = 2;
    localparam int ADDR_BLC_GR       = 3;
    localparam int ADDR_BLC_GB       = 4;
    localparam int ADDR_BLC_B        = 5;
    localparam int ADDR_NR_LEVEL     = 6;
    localparam int ADDR_DGAIN_GAIN   = 7;
    localparam int ADDR_DGAIN_OFFSET = 8;
    localparam int ADDR_WB_RGAIN     = 9;
    localparam int ADDR_WB_GGAIN     = 10;
    localparam int ADDR_WB_BGAIN     = 11;

    // Bit positions inside the enable register
    localparam int EN_DPC      = 0;
    localparam int EN_BLC      = 1;
    localparam int EN_BNR      = 2;
    localparam int EN_DGAIN    = 3;
    localparam int EN_DEMOSIC  = 4;
    localparam int EN_WB       = 5;
    localparam int EN_CCM      = 6;
    localparam int EN_CSC      = 7;
    localparam int EN_GAMMA    = 8;
    localparam int EN_NR2D     = 9;
    localparam int EN_EE       = 10;
    localparam int EN_STAT_AE  = 11;
    localparam int EN_STAT_AWB = 12;

    // 4.4 fixed point 1.0
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } cfg_state_t;

    function automatic int field_width(input int idx, input int bits);
        case (idx)
            ADDR_EN:         return EN_W;
            ADDR_NR_LEVEL:   return NR_W;
            ADDR_DGAIN_GAIN,
            ADDR_WB_RGAIN,
            ADDR_WB_GGAIN,
            ADDR_WB_BGAIN:   return GAIN_W;
            default:         return bits;
        endcase
    endfunction

    // Fields are packed back to back in address order.
    function automatic int field_offset(input int idx, input int bits);
        int off;
        off = 0;
        for (int i = 0; i < idx; i++) begin
            off += field_width(i, bits);
        end
        return off;
    endfunction

    function automatic int cfg_vec_width(input int bits);
        return field_offset(NUM_FIELDS, bits);
    endfunction

    function automatic logic [CFG_DW-1:0] field_reset(input int idx);
        case (idx)
            ADDR_DGAIN_GAIN,
            ADDR_WB_RGAIN,
            ADDR_WB_GGAIN,
            ADDR_WB_BGAIN:   return {8'h00, GAIN_UNITY};
            default:         return '0;
        endcase
    endfunction

    // Reset image of the whole packed vector; callers slice the low bits.
    function automatic logic [NUM_FIELDS*CFG_DW-1:0] cfg_reset_vec(input int bits);
        logic [NUM_FIELDS*CFG_DW-1:0] vec;
        vec = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            vec |= (NUM_FIELDS*CFG_DW)'(field_reset(i)) << field_offset(i, bits);
        end
        return vec;
    endfunction

endpackage

// File: rtl/isp_vsync_edge.sv
// Frame boundary detector shared by the configuration controller and the
// statistics blocks.
//   pclk, rst_n : clock, asynchronous active-low reset
//   in_vsync    : frame sync, high during a frame
//   vs_rise     : combinational, high in the cycle in_vsync is first seen high
//   frame_cnt   : count of vs_rise events, wraps
module isp_vsync_edge #(
    parameter int FCNT_BITS = 16
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic                 in_vsync,
    output logic                 vs_rise,
    output logic [FCNT_BITS-1:0] frame_cnt
);

    logic                 vs_d_reg;
    logic [FCNT_BITS-1:0] frame_cnt_reg;

    assign vs_rise   = in_vsync & ~vs_d_reg;
    assign frame_cnt = frame_cnt_reg;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d_reg      <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            vs_d_reg <= in_vsync;
            if (vs_rise) begin
                frame_cnt_reg <= frame_cnt_reg + FCNT_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/isp_cfg_sync_ctrl.sv
// Frame-synchronous configuration controller for the raw ISP front end.
// The host fills a shadow bank through a valid/ready port and arms a commit;
// the shadow bank is copied to the active bank only at a frame boundary (or
// after an optional timeout), so pipeline stages never see a mid-frame change.
//   pclk, rst_n          : clock, asynchronous active-low reset
//   in_vsync             : frame sync, high during a frame
//   cfg_*                : host register port (valid/ready, read data 1 cycle later)
//   commit_req           : one-cycle pulse arming a commit
//   commit_pending       : commit armed and not yet applied
//   cfg_applied          : one-cycle pulse, active bank just updated
//   timeout_flag         : sticky, last apply was forced by the timeout
//   addr_err             : sticky, an unmapped address was accessed
//   frame_cnt            : in_vsync rising-edge count
//   en_o .. wb_bgain     : active stage enables and coefficients
module isp_cfg_sync_ctrl
    import isp_cfg_pkg::*;
#(
    parameter int          BITS           = 8,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int          FCNT_BITS      = 16
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic                 in_vsync,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_addr,
    input  logic [15:0]          cfg_wdata,
    output logic [15:0]          cfg_rdata,
    output logic                 cfg_rvalid,
    input  logic                 commit_req,
    output logic                 commit_pending,
    output logic                 cfg_applied,
    output logic                 timeout_flag,
    output logic                 addr_err,
    output logic [FCNT_BITS-1:0] frame_cnt,
    output logic [12:0]          en_o,
    output logic [BITS-1:0]      dpc_threshold,
    output logic [BITS-1:0]      blc_r,
    output logic [BITS-1:0]      blc_gr,
    output logic [BITS-1:0]      blc_gb,
    output logic [BITS-1:0]      blc_b,
    output logic [BITS-1:0]      dgain_offset,
    output logic [3:0]           nr_level,
    output logic [7:0]           dgain_gain,
    output logic [7:0]           wb_rgain,
    output logic [7:0]           wb_ggain,
    output logic [7:0]           wb_bgain
);

    localparam int VEC_W  = cfg_vec_width(BITS);
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (TIMEOUT_CYCLES > 0) ? WAIT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [NUM_FIELDS*CFG_DW-1:0] RESET_ALL = cfg_reset_vec(BITS);
    localparam logic [VEC_W-1:0] RESET_VEC = RESET_ALL[VEC_W-1:0];

    cfg_state_t        state_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              forced_reg;
    logic              cfg_applied_reg;
    logic              timeout_flag_reg;

    logic [VEC_W-1:0]  shadow_reg;
    logic [VEC_W-1:0]  shadow_next;
    logic [VEC_W-1:0]  active_reg;
    logic [15:0]       cfg_rdata_reg;
    logic              cfg_rvalid_reg;
    logic              addr_err_reg;

    logic              vs_rise;
    logic              accept;
    logic              wr_en;
    logic              rd_en;
    logic              addr_mapped;
    logic [15:0]       rd_field [16];

    // Upper write-data bits beyond the widest field are intentionally ignored.
    logic              unused_wdata;
    assign unused_wdata = ^cfg_wdata;

    isp_vsync_edge #(
        .FCNT_BITS (FCNT_BITS)
    ) u_vsync_edge (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .in_vsync  (in_vsync),
        .vs_rise   (vs_rise),
        .frame_cnt (frame_cnt)
    );

    // Writes are blocked during the copy cycle so shadow never changes under it.
    assign cfg_ready      = (state_reg != ST_APPLY);
    assign commit_pending = (state_reg != ST_IDLE);
    assign accept         = cfg_valid & cfg_ready;
    assign wr_en          = accept & cfg_we;
    assign rd_en          = accept & ~cfg_we;
    assign addr_mapped    = (cfg_addr < 4'(NUM_FIELDS));

    // Per-address write slice and zero-extended read tap. Unmapped addresses
    // match no write slice and read as zero.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_field
            if (gi < NUM_FIELDS) begin : g_mapped
                localparam int OFF = field_offset(gi, BITS);
                localparam int W   = field_width(gi, BITS);
                assign shadow_next[OFF +: W] =
                    (wr_en && cfg_addr == 4'(gi)) ? cfg_wdata[W-1:0] : shadow_reg[OFF +: W];
                assign rd_field[gi] = 16'(shadow_reg[OFF +: W]);
            end else begin : g_unmapped
                assign rd_field[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg     <= RESET_VEC;
            active_reg     <= RESET_VEC;
            cfg_rdata_reg  <= '0;
            cfg_rvalid_reg <= 1'b0;
            addr_err_reg   <= 1'b0;
        end else begin
            shadow_reg     <= shadow_next;
            cfg_rvalid_reg <= rd_en;
            if (rd_en) begin
                cfg_rdata_reg <= rd_field[cfg_addr];
            end
            if (accept && !addr_mapped) begin
                addr_err_reg <= 1'b1;
            end
            if (state_reg == ST_APPLY) begin
                active_reg <= shadow_reg;
            end
        end
    end

    // Commit FSM. forced_reg records why PENDING left so APPLY can update the
    // sticky timeout flag together with the copy.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            wait_cnt_reg     <= '0;
            forced_reg       <= 1'b0;
            cfg_applied_reg  <= 1'b0;
            timeout_flag_reg <= 1'b0;
        end else begin
            cfg_applied_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (commit_req) begin
                        state_reg    <= ST_PENDING;
                        wait_cnt_reg <= '0;
                    end
                end
                ST_PENDING: begin
                    // A frame edge wins over a coincident timeout.
                    if (vs_rise) begin
                        state_reg  <= ST_APPLY;
                        forced_reg <= 1'b0;
                    end else if (TIMEOUT_EN && wait_cnt_reg == WAIT_LAST) begin
                        state_reg  <= ST_APPLY;
                        forced_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                ST_APPLY: begin
                    cfg_applied_reg  <= 1'b1;
                    timeout_flag_reg <= forced_reg;
                    if (commit_req) begin
                        state_reg    <= ST_PENDING;
                        wait_cnt_reg <= '0;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_rdata    = cfg_rdata_reg;
    assign cfg_rvalid   = cfg_rvalid_reg;
    assign cfg_applied  = cfg_applied_reg;
    assign timeout_flag = timeout_flag_reg;
    assign addr_err     = addr_err_reg;

    assign en_o          = active_reg[field_offset(ADDR_EN, BITS)           +: EN_W];
    assign dpc_threshold = active_reg[field_offset(ADDR_DPC_THR, BITS)      +: BITS];
    assign blc_r         = active_reg[field_offset(ADDR_BLC_R, BITS)        +: BITS];
    assign blc_gr        = active_reg[field_offset(ADDR_BLC_GR, BITS)       +: BITS];
    assign blc_gb        = active_reg[field_offset(ADDR_BLC_GB, BITS)       +: BITS];
    assign blc_b         = active_reg[field_offset(ADDR_BLC_B, BITS)        +: BITS];
    assign nr_level      = active_reg[field_offset(ADDR_NR_LEVEL, BITS)     +: NR_W];
    assign dgain_gain    = active_reg[field_offset(ADDR_DGAIN_GAIN, BITS)   +: GAIN_W];
    assign dgain_offset  = active_reg[field_offset(ADDR_DGAIN_OFFSET, BITS) +: BITS];
    assign wb_rgain      = active_reg[field_offset(ADDR_WB_RGAIN, BITS)     +: GAIN_W];
    assign wb_ggain      = active_reg[field_offset(ADDR_WB_GGAIN, BITS)     +: GAIN_W];
    assign wb_bgain      = active_reg[field_offset(ADDR_WB_BGAIN, BITS)     +: GAIN_W];

endmodule

// File: tb/tb_isp_cfg_sync_ctrl.sv
// Scoreboard bench for isp_cfg_sync_ctrl. Stimulus pushes hand-computed
// expectations; a negedge monitor pops them on cfg_rvalid / cfg_applied.
// FCNT_BITS is reduced to 8 so the frame counter wrap is reachable quickly.
module tb_isp_cfg_sync_ctrl;

    localparam int BITS  = 8;
    localparam int FCNT  = 8;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vsync = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic [15:0] cfg_rdata;
    logic        cfg_rvalid;
    logic        commit_req = 1'b0;
    logic        commit_pending;
    logic        cfg_applied;
    logic        timeout_flag;
    logic        addr_err;
    logic [FCNT-1:0] frame_cnt;
    logic [12:0] en_o;
    logic [BITS-1:0] dpc_threshold, blc_r, blc_gr, blc_gb, blc_b, dgain_offset;
    logic [3:0]  nr_level;
    logic [7:0]  dgain_gain, wb_rgain, wb_ggain, wb_bgain;

    isp_cfg_sync_ctrl #(
        .BITS           (BITS),
        .TIMEOUT_CYCLES (100),
        .FCNT_BITS      (FCNT)
    ) dut (
        .pclk           (pclk),
        .rst_n          (rst_n),
        .in_vsync       (in_vsync),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_rdata      (cfg_rdata),
        .cfg_rvalid     (cfg_rvalid),
        .commit_req     (commit_req),
        .commit_pending (commit_pending),
        .cfg_applied    (cfg_applied),
        .timeout_flag   (timeout_flag),
        .addr_err       (addr_err),
        .frame_cnt      (frame_cnt),
        .en_o           (en_o),
        .dpc_threshold  (dpc_threshold),
        .blc_r          (blc_r),
        .blc_gr         (blc_gr),
        .blc_gb         (blc_gb),
        .blc_b          (blc_b),
        .dgain_offset   (dgain_offset),
        .nr_level       (nr_level),
        .dgain_gain     (dgain_gain),
        .wb_rgain       (wb_rgain),
        .wb_ggain       (wb_ggain),
        .wb_bgain       (wb_bgain)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } rd_t;

    typedef struct packed {
        logic [12:0] en;
        logic [7:0]  blc_r;
        logic [7:0]  blc_gr;
        logic [7:0]  dgain;
        logic [7:0]  wbr;
        logic [7:0]  wbb;
        logic        tflag;
    } ap_t;

    rd_t rd_q[$];
    ap_t ap_q[$];
    rd_t mon_rd;
    ap_t mon_ap;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per DUT output event.
    always @(negedge pclk) begin
        if (rst_n === 1'b1) begin
            if (cfg_rvalid) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: got rdata %h, required no read response", cfg_rdata);
                end else begin
                    mon_rd = rd_q.pop_front();
                    check("rdata", 32'(cfg_rdata), 32'(mon_rd.data));
                    check("rvalid_latency_cycle", cyc, mon_rd.cyc);
                    $display("read  rdata=%h exp=%h cyc=%0d", cfg_rdata, mon_rd.data, cyc);
                end
            end
            if (cfg_applied) begin
                if (ap_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_apply: got cfg_applied pulse, required none");
                end else begin
                    mon_ap = ap_q.pop_front();
                    check("apply_en", 32'(en_o), 32'(mon_ap.en));
                    check("apply_blc", {16'h0, blc_r, blc_gr}, {16'h0, mon_ap.blc_r, mon_ap.blc_gr});
                    check("apply_gains", {8'h0, dgain_gain, wb_rgain, wb_bgain},
                          {8'h0, mon_ap.dgain, mon_ap.wbr, mon_ap.wbb});
                    check("apply_timeout_flag", 32'(timeout_flag), 32'(mon_ap.tflag));
                    $display("apply en=%h blc_r=%h blc_gr=%h dg=%h wbr=%h wbb=%h tflag=%b",
                             en_o, blc_r, blc_gr, dgain_gain, wb_rgain, wb_bgain, timeout_flag);
                end
            end
        end
    end

    task automatic cycle(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // One host access; commit_req is always a single-edge pulse, so it is
    // dropped after every edge seen here.
    task automatic cfg_access(input logic we, input logic [3:0] addr, input logic [15:0] wdata,
                              output int stalls, output int acc_cyc);
        logic r;
        int   guard;
        cfg_valid = 1'b1;
        cfg_we    = we;
        cfg_addr  = addr;
        cfg_wdata = wdata;
        stalls    = 0;
        guard     = 0;
        do begin
            @(negedge pclk);
            r = cfg_ready;
            @(posedge pclk);
            #1;
            commit_req = 1'b0;
            if (!r) stalls++;
            guard++;
        end while (!r && guard < 20);
        acc_cyc   = cyc;
        cfg_valid = 1'b0;
        cfg_we    = 1'b0;
        check("cfg_ready_eventually", 32'(r), 32'd1);
        $display("%s addr=%0d wdata=%h stalls=%0d", we ? "write" : "rdreq", addr, wdata, stalls);
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [15:0] wdata);
        int s, c;
        cfg_access(1'b1, addr, wdata, s, c);
    endtask

    task automatic cfg_read(input logic [3:0] addr, input logic [15:0] exp);
        int s, c;
        cfg_access(1'b0, addr, 16'h0, s, c);
        rd_q.push_back('{exp, c});
    endtask

    task automatic commit();
        commit_req = 1'b1;
        cycle(1);
        commit_req = 1'b0;
    endtask

    task automatic push_ap(input logic [12:0] en, input logic [7:0] br, input logic [7:0] bgr,
                           input logic [7:0] dg, input logic [7:0] wr, input logic [7:0] wbb,
                           input logic tf);
        ap_q.push_back('{en, br, bgr, dg, wr, wbb, tf});
    endtask

    logic [15:0] shadow_tbl [12] = '{16'h000F, 16'h00FF, 16'h0040, 16'h0055, 16'h0000, 16'h0000,
                                     16'h000B, 16'h0034, 16'h0000, 16'h0020, 16'h0010, 16'h0030};

    initial begin
        int n;
        int stalls;
        int acc;

        // Reset with in_vsync toggling
        for (int i = 0; i < 6; i++) begin
            in_vsync = ~in_vsync;
            cycle(1);
        end
        check("rst_en_o", 32'(en_o), 32'h0);
        check("rst_wb_gains", {8'h0, wb_rgain, wb_ggain, wb_bgain}, 32'h00101010);
        check("rst_dgain_gain", 32'(dgain_gain), 32'h10);
        check("rst_blc_dpc", {blc_r, blc_gr, blc_b, dpc_threshold}, 32'h0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_status", {28'h0, commit_pending, cfg_applied, cfg_rvalid, addr_err}, 32'h0);
        check("rst_rdata", 32'(cfg_rdata), 32'h0);
        @(negedge pclk);
        rst_n = 1'b1;
        cycle(2);

        // Shadow isolation and truncation
        cfg_write(4'd2, 16'h0040);
        cfg_read(4'd2, 16'h0040);
        cfg_read(4'd1, 16'h0000);
        cfg_write(4'd7, 16'h1234);
        cfg_read(4'd7, 16'h0034);
        cycle(3);
        check("blc_r_no_commit", 32'(blc_r), 32'h0);
        check("dgain_no_commit", 32'(dgain_gain), 32'h10);

        // Frame-synchronous apply
        in_vsync = 1'b1;
        cycle(1);
        check("frame_cnt_first_rise", 32'(frame_cnt), 32'd1);
        cfg_write(4'd0, 16'hE00F);
        commit();
        check("pending_after_commit", 32'(commit_pending), 32'd1);
        cycle(3);
        commit();           // absorbed while pending
        cycle(5);
        check("en_mid_frame", 32'(en_o), 32'h0);
        in_vsync = 1'b0;
        cycle(5);
        check("en_before_rise", 32'(en_o), 32'h0);
        push_ap(13'h00F, 8'h40, 8'h00, 8'h34, 8'h10, 8'h10, 1'b0);
        in_vsync = 1'b1;
        cycle(1);
        check("en_in_apply_cycle", 32'(en_o), 32'h0);
        check("ready_low_in_apply", 32'(cfg_ready), 32'd0);
        cycle(1);
        check("en_after_apply", 32'(en_o), 32'h00F);
        check("pending_cleared", 32'(commit_pending), 32'd0);
        cycle(3);

        // Timeout-forced apply
        in_vsync = 1'b0;
        cfg_write(4'd9, 16'h0020);
        commit_req = 1'b1;
        cycle(1);
        commit_req = 1'b0;
        push_ap(13'h00F, 8'h40, 8'h00, 8'h34, 8'h20, 8'h10, 1'b1);
        n = 0;
        while (!cfg_applied && n < 300) begin
            cycle(1);
            n++;
        end
        check("timeout_apply_latency", n, 101);
        check("timeout_flag_set", 32'(timeout_flag), 32'd1);
        cycle(2);
        cfg_write(4'd11, 16'h0030);
        commit();
        push_ap(13'h00F, 8'h40, 8'h00, 8'h34, 8'h20, 8'h30, 1'b0);
        cycle(4);
        in_vsync = 1'b1;
        cycle(3);
        check("timeout_flag_cleared", 32'(timeout_flag), 32'd0);
        check("wb_bgain_applied", 32'(wb_bgain), 32'h30);

        // Contention: write and commit_req during the APPLY cycle
        in_vsync = 1'b0;
        commit();
        cycle(3);
        push_ap(13'h00F, 8'h40, 8'h00, 8'h34, 8'h20, 8'h30, 1'b0);
        in_vsync = 1'b1;
        cycle(1);           // now in APPLY
        commit_req = 1'b1;
        cfg_access(1'b1, 4'd3, 16'h0055, stalls, acc);
        check("apply_stall_cycles", stalls, 1);
        check("pending_after_apply_commit", 32'(commit_pending), 32'd1);
        check("blc_gr_shadow_only", 32'(blc_gr), 32'h0);
        cfg_read(4'd3, 16'h0055);
        in_vsync = 1'b0;
        cycle(3);
        push_ap(13'h00F, 8'h40, 8'h55, 8'h34, 8'h20, 8'h30, 1'b0);
        in_vsync = 1'b1;
        cycle(3);
        check("blc_gr_second_apply", 32'(blc_gr), 32'h55);
        check("pending_done", 32'(commit_pending), 32'd0);

        // Unmapped access and full shadow readback
        cfg_write(4'd13, 16'hFFFF);
        check("addr_err_set", 32'(addr_err), 32'd1);
        cfg_write(4'd1, 16'h01FF);
        cfg_write(4'd6, 16'h00AB);
        cfg_read(4'd13, 16'h0000);
        for (int a = 0; a < 12; a++) begin
            cfg_read(4'(a), shadow_tbl[a]);
        end
        cycle(3);
        check("addr_err_sticky", 32'(addr_err), 32'd1);

        // Async reset while PENDING
        in_vsync = 1'b0;
        commit();
        cycle(3);
        check("pending_before_reset", 32'(commit_pending), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_pending", 32'(commit_pending), 32'd0);
        check("async_rst_en", 32'(en_o), 32'h0);
        check("async_rst_gains", {8'h0, wb_rgain, dgain_gain, wb_bgain}, 32'h00101010);
        check("async_rst_blc_gr", 32'(blc_gr), 32'h0);
        check("async_rst_addr_err", 32'(addr_err), 32'd0);
        check("async_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
        cycle(10);
        cfg_read(4'd0, 16'h0000);
        cfg_read(4'd10, 16'h0010);
        cycle(2);

        // Frame counter wrap
        for (int i = 0; i < 255; i++) begin
            in_vsync = 1'b1;
            cycle(1);
            in_vsync = 1'b0;
            cycle(1);
        end
        check("frame_cnt_max", 32'(frame_cnt), 32'hFF);
        in_vsync = 1'b1;
        cycle(1);
        check("frame_cnt_wrap", 32'(frame_cnt), 32'h0);
        cycle(5);

        check("read_queue_drained", rd_q.size(), 0);
        check("apply_queue_drained", ap_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/isp_cfg_sync_ctrl.md
Name: isp_cfg_sync_ctrl

Overview:
- Frame-synchronous configuration controller for the raw ISP front end (DPC, BLC, BNR, DGAIN, WB stages).
- Host writes a shadow register bank through a valid/ready port, then requests a commit.
- The block copies shadow to active registers only at a frame boundary (rising edge of in_vsync), so stage enables and coefficients never change mid-frame.
- Active outputs drive the stage enable/parameter inputs of the pipeline top.

Parameters:
- BITS, 8, pixel bit depth; width of threshold/black-level/offset fields.
- TIMEOUT_CYCLES, 0, pclk cycles a pending commit waits for a frame boundary before a forced apply; 0 disables the timeout.
- FCNT_BITS, 16, width of the frame counter.

Ports:
- pclk  in  1  pixel clock; sole clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_vsync  in  1  frame sync from the input pipeline stage; high during a frame.
- cfg_valid  in  1  host write/read request.
- cfg_ready  out  1  request accepted this cycle when valid&ready.
- cfg_we  in  1  1 = write, 0 = read.
- cfg_addr  in  4  register index.
- cfg_wdata  in  16  write data (LSB-aligned).
- cfg_rdata  out  16  shadow read data.
- cfg_rvalid  out  1  one-cycle pulse; rdata valid.
- commit_req  in  1  one-cycle pulse; arm a commit.
- commit_pending  out  1  commit armed, not yet applied.
- cfg_applied  out  1  one-cycle pulse on apply.
- timeout_flag  out  1  sticky; last apply was forced by timeout.
- addr_err  out  1  sticky; access to an unmapped address.
- frame_cnt  out  FCNT_BITS  count of in_vsync rising edges, wraps.
- en_o  out  13  active enables {stat_awb,stat_ae,ee,nr2d,gamma,csc,ccm,wb,demosic,dgain,bnr,blc,dpc}; bit0 = dpc.
- dpc_threshold, blc_r, blc_gr, blc_gb, blc_b, dgain_offset  out  BITS each  active values.
- nr_level  out  4  active value.
- dgain_gain, wb_rgain, wb_ggain, wb_bgain  out  8 each  active values, 4.4 fixed point.

Behaviour:
- Register map:
  - 0 enables[12:0]
  - 1 dpc_threshold
  - 2–5 blc r/gr/gb/b
  - 6 nr_level
  - 7 dgain_gain
  - 8 dgain_offset
  - 9–11 wb r/g/b gains
  - 12–15 unmapped
- Writes truncate wdata to the field width. Reads zero-extend.
- Reset values, shadow and active: enables 0; gains 8'h10 (unity); all other fields 0.
- Reset values, status/handshake outputs: cfg_rdata 0; commit_pending, cfg_applied, cfg_rvalid, timeout_flag, addr_err 0; frame_cnt 0; cfg_ready 1.
- Write: shadow updates on the accept edge. Active outputs are unaffected until apply.
- Read: cfg_rvalid and cfg_rdata (shadow value) appear 1 cycle after accept.
- Unmapped access: the request is accepted; writes are dropped; reads return 0; addr_err is set. addr_err clears only by reset.
- Frame boundary: in_vsync is registered once; vs_rise = in_vsync & ~vs_d. frame_cnt increments on every vs_rise, independent of state.
- FSM states:
  - IDLE: commit_req -> PENDING.
  - PENDING: vs_rise, or (TIMEOUT_CYCLES != 0 and wait counter == TIMEOUT_CYCLES-1) -> APPLY. The wait counter clears on entry to PENDING.
  - APPLY (1 cycle): copy shadow to active; pulse cfg_applied. Set timeout_flag if the apply was forced by timeout; clear it if triggered by vs_rise. Exit to PENDING if commit_req was seen during APPLY, else IDLE.
- cfg_ready = 0 in APPLY only, so a write never races the copy.
- commit_pending = (state != IDLE).
- commit_req while PENDING is absorbed; only one apply results.
- Active outputs change exactly 1 cycle after the vs_rise cycle (vs_rise in PENDING -> APPLY on the next edge; outputs registered at the end of APPLY). Pipeline stages see the new value before the first active line.
- Async reset mid-PENDING/APPLY returns to IDLE with reset values; no cfg_applied pulse.

Decomposition:
- Shared package isp_cfg_pkg:
  - register address localparams;
  - enable bit index constants;
  - reset default constants (GAIN_UNITY = 8'h10);
  - FSM state encoding.
- One sub-module, isp_vsync_edge: registers in_vsync, produces vs_rise, and holds frame_cnt. It is reusable by the stats blocks.

Test Plan:
- Reset: rst_n low with in_vsync toggling -> all active outputs at defaults; wb gains 8'h10; frame_cnt 0; cfg_ready 1.
- Shadow isolation: write addr 2 = 16'h0040, read addr 2 -> rdata 16'h0040 one cycle later; blc_r stays 0 with no commit.
- Frame-sync apply: write en = 13'h00F, commit_req mid-frame -> en_o unchanged until vs_rise; en_o = 13'h00F one cycle after vs_rise with a single cfg_applied pulse; commit_pending 1 -> 0.
- Timeout: TIMEOUT_CYCLES = 100, in_vsync held low, commit_req -> apply on cycle 100 after PENDING entry; timeout_flag 1. Next commit applied on vs_rise -> timeout_flag 0.
- Contention: cfg_valid write held during the APPLY cycle -> cfg_ready 0 for exactly 1 cycle; the write lands in shadow only. commit_req during APPLY -> returns to PENDING and applies at the next vs_rise.
- Errors and reset: write addr 13 -> addr_err 1, no field changes. Async reset asserted in PENDING -> IDLE, no cfg_applied pulse. frame_cnt wraps 16'hFFFF -> 0.
